// File: rtl/temporizador_pkg.sv
// rtl/temporizador_pkg.sv - shared constants for the rco-driven down-counting timer
// Holds the default count width and the 2-bit FSM state encoding.
package temporizador_pkg;

  localparam int DEFAULT_WIDTH = 10;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

endpackage

// File: rtl/temporizador_rco.sv
// rtl/temporizador_rco.sv - programmable down-counting timer clocked by the prescaler rco tick
// Ports:
//   clk          system clock, rising edge
//   reset        synchronous active-high reset
//   tick_in      rco pulse from the prescaler, counted as a level (one tick per high cycle)
//   load         load load_val into the count and the reload register, return to IDLE
//   load_val     value to load
//   start        begin counting from IDLE, or restart from DONE using the reload register
//   pause        level; while high in RUN/HOLD the count is frozen
//   auto_reload  level; on terminal count reload instead of stopping
//   count        current count (registered)
//   busy         high while in RUN or HOLD (registered)
//   done         one-cycle pulse in the cycle after the terminal tick
module temporizador_rco
  import temporizador_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick_in,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic             pause,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done
);

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [WIDTH-1:0] count_nxt;
  logic [WIDTH-1:0] reload;
  logic             done_nxt;

  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] ZERO = '0;

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    done_nxt  = 1'b0;
    if (load) begin
      // load wins over start and tick in the same cycle
      state_nxt = ST_IDLE;
      count_nxt = load_val;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start && (count != ZERO)) begin
            state_nxt = ST_RUN;
          end
        end
        ST_RUN: begin
          if (pause) begin
            state_nxt = ST_HOLD;
          end else if (tick_in) begin
            if (count > ONE) begin
              count_nxt = count - ONE;
            end else if (count == ONE) begin
              // terminal tick: either wrap to the reload value or park in DONE
              done_nxt = 1'b1;
              if (auto_reload) begin
                count_nxt = reload;
              end else begin
                count_nxt = ZERO;
                state_nxt = ST_DONE;
              end
            end
          end
        end
        ST_HOLD: begin
          // a tick arriving with the pause release is still ignored
          if (!pause) begin
            state_nxt = ST_RUN;
          end
        end
        ST_DONE: begin
          if (start && (reload != ZERO)) begin
            count_nxt = reload;
            state_nxt = ST_RUN;
          end
        end
        default: begin
          state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      count  <= ZERO;
      reload <= ZERO;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      done  <= done_nxt;
      busy  <= (state_nxt == ST_RUN) || (state_nxt == ST_HOLD);
      if (load) begin
        reload <= load_val;
      end
    end
  end

endmodule

// File: tb/tb_temporizador_rco.sv
// tb/tb_temporizador_rco.sv - self-checking bench for temporizador_rco
module tb_temporizador_rco;

  localparam int W = 10;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         tick_in = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] load_val = '0;
  logic         start = 1'b0;
  logic         pause = 1'b0;
  logic         auto_reload = 1'b0;
  logic [W-1:0] count;
  logic         busy;
  logic         done;

  int passed = 0;
  int total  = 0;

  temporizador_rco #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .tick_in(tick_in), .load(load), .load_val(load_val),
    .start(start), .pause(pause), .auto_reload(auto_reload),
    .count(count), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Reference model: timer described as a mode plus integer count
  typedef enum {M_IDLE, M_RUN, M_HOLD, M_DONE} mode_t;
  mode_t m_mode = M_IDLE;
  int    m_cnt = 0;
  int    m_rel = 0;
  bit    m_done = 0;

  function automatic void model_edge();
    m_done = 0;
    if (reset) begin
      m_cnt = 0; m_rel = 0; m_mode = M_IDLE;
    end else if (load) begin
      m_cnt = int'(load_val); m_rel = int'(load_val); m_mode = M_IDLE;
    end else begin
      if (m_mode == M_IDLE) begin
        if (start && m_cnt != 0) m_mode = M_RUN;
      end else if (m_mode == M_RUN) begin
        if (pause) m_mode = M_HOLD;
        else if (tick_in && m_cnt > 0) begin
          m_cnt = m_cnt - 1;
          if (m_cnt == 0) begin
            m_done = 1;
            if (auto_reload) m_cnt = m_rel;
            else m_mode = M_DONE;
          end
        end
      end else if (m_mode == M_HOLD) begin
        if (!pause) m_mode = M_RUN;
      end else begin
        if (start && m_rel != 0) begin
          m_cnt = m_rel; m_mode = M_RUN;
        end
      end
    end
  endfunction

  function automatic bit model_busy();
    return (m_mode == M_RUN) || (m_mode == M_HOLD);
  endfunction

  // Advance one clock: model follows the inputs present at the edge, outputs settle by #1
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic quiet();
    reset = 0; tick_in = 0; load = 0; start = 0; pause = 0;
  endtask

  task automatic load_and_start(input int v);
    quiet();
    load_val = W'(v); load = 1; step();
    load = 0; start = 1; step();
    start = 0;
  endtask

  task automatic test_reset();
    reset = 1; step(); step();
    total++;
    if (count !== '0 || busy !== 1'b0 || done !== 1'b0)
      $display("FAIL reset: count=%0d busy=%b done=%b, want 0/0/0", count, busy, done);
    else passed++;
    reset = 0;
  endtask

  task automatic test_one_shot();
    auto_reload = 0;
    load_and_start(3);
    total++;
    if (count !== 10'd3 || busy !== 1'b1) $display("FAIL one_shot_start: count=%0d busy=%b, want 3/1", count, busy);
    else passed++;
    for (int i = 0; i < 3; i++) begin
      repeat (4) step();
      tick_in = 1; step(); tick_in = 0;
      total++;
      if (count !== W'(2 - i) || done !== (i == 2))
        $display("FAIL one_shot_tick%0d: count=%0d done=%b, want %0d/%0d", i, count, done, 2 - i, i == 2);
      else passed++;
    end
    step();
    total++;
    if (done !== 1'b0 || busy !== 1'b0 || count !== '0)
      $display("FAIL one_shot_after: done=%b busy=%b count=%0d, want 0/0/0", done, busy, count);
    else passed++;
  endtask

  task automatic test_auto_reload();
    auto_reload = 1;
    load_and_start(2);
    tick_in = 1;
    for (int i = 0; i < 6; i++) begin
      step();
      total++;
      if (count !== W'((i % 2 == 0) ? 1 : 2) || done !== (i % 2 == 1) || busy !== 1'b1)
        $display("FAIL auto_reload_tick%0d: count=%0d done=%b busy=%b, want %0d/%0d/1",
                 i, count, done, busy, (i % 2 == 0) ? 1 : 2, i % 2);
      else passed++;
    end
    tick_in = 0; auto_reload = 0;
  endtask

  task automatic test_pause();
    load_and_start(5);
    tick_in = 1; step(); step(); tick_in = 0;
    pause = 1; tick_in = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      total++;
      if (count !== 10'd3 || busy !== 1'b1)
        $display("FAIL pause_hold%0d: count=%0d busy=%b, want 3/1", i, count, busy);
      else passed++;
    end
    pause = 0; tick_in = 0; step();
    tick_in = 1; step(); tick_in = 0;
    total++;
    if (count !== 10'd2 || busy !== 1'b1) $display("FAIL pause_resume: count=%0d busy=%b, want 2/1", count, busy);
    else passed++;
  endtask

  task automatic test_reset_mid_run();
    load_and_start(6);
    tick_in = 1; step(); step();
    reset = 1; step(); reset = 0; tick_in = 0;
    total++;
    if (count !== '0 || busy !== 1'b0 || done !== 1'b0)
      $display("FAIL reset_mid_run: count=%0d busy=%b done=%b, want 0/0/0", count, busy, done);
    else passed++;
    step();
    total++;
    if (done !== 1'b0 || busy !== 1'b0) $display("FAIL reset_mid_run_after: done=%b busy=%b, want 0/0", done, busy);
    else passed++;
  endtask

  task automatic test_load_priority();
    load_and_start(8);
    tick_in = 1; step();
    load_val = 10'd9; load = 1; start = 1; step();
    quiet();
    total++;
    if (count !== 10'd9 || busy !== 1'b0) $display("FAIL load_priority: count=%0d busy=%b, want 9/0", count, busy);
    else passed++;
    load_val = '0; load = 1; step(); load = 0;
    start = 1; step(); start = 0; step();
    total++;
    if (count !== '0 || busy !== 1'b0) $display("FAIL start_zero: count=%0d busy=%b, want 0/0", count, busy);
    else passed++;
  endtask

  task automatic test_restart_from_done();
    auto_reload = 0;
    load_and_start(3);
    tick_in = 1; repeat (3) step(); tick_in = 0; step();
    start = 1; step(); start = 0;
    total++;
    if (count !== 10'd3 || busy !== 1'b1) $display("FAIL restart: count=%0d busy=%b, want 3/1", count, busy);
    else passed++;
    tick_in = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (done !== (i == 2)) $display("FAIL restart_done%0d: done=%b, want %0d", i, done, i == 2);
      else passed++;
    end
    tick_in = 0;
  endtask

  task automatic test_random();
    reset = 1; step(); quiet();
    for (int n = 0; n < 3000; n++) begin
      reset       = ($urandom_range(0, 199) == 0);
      load        = ($urandom_range(0, 19) == 0);
      load_val    = ($urandom_range(0, 3) == 0) ? W'($urandom) : W'($urandom_range(0, 5));
      start       = ($urandom_range(0, 4) == 0);
      pause       = ($urandom_range(0, 6) == 0);
      tick_in     = $urandom_range(0, 1);
      if ($urandom_range(0, 15) == 0) auto_reload = ~auto_reload;
      step();
      total++;
      if (count !== W'(m_cnt) || busy !== model_busy() || done !== m_done)
        $display("FAIL random_cycle%0d: count=%0d busy=%b done=%b, want %0d/%b/%b",
                 n, count, busy, done, m_cnt, model_busy(), m_done);
      else passed++;
    end
    quiet();
  endtask

  initial begin
    test_reset();
    test_one_shot();
    test_auto_reload();
    test_pause();
    test_reset_mid_run();
    test_load_priority();
    test_restart_from_done();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/temporizador_rco.md
Name: temporizador_rco

Overview:
Programmable down-counting timer that consumes the `rco` ripple-carry pulse produced by the free-running `Contador2Bit` prescaler.
- Each `rco` tick decrements a loaded count.
- Reaching zero raises a one-cycle `done` pulse, with optional auto-reload for periodic events.
- Sits downstream of the prescaler. It is the receiving end of the `rco` interface and feeds timing events to the control logic of the project.

Parameters:
- WIDTH, 10, width of the count, load value and reload register.

Ports:
- clk  input  1  system clock; all logic updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- tick_in  input  1  `rco` from the prescaler, synchronous to `clk`; each cycle it is high counts as one tick.
- load  input  1  load `load_val` into the count and the reload register.
- load_val  input  WIDTH  value to load.
- start  input  1  begin or resume counting.
- pause  input  1  level; while high, ticks are ignored.
- auto_reload  input  1  level; when high, the count restarts from the reload register on reaching zero.
- count  output  WIDTH  current count value (registered).
- busy  output  1  high in RUN and HOLD.
- done  output  1  one-cycle pulse on terminal count.

Behaviour:
- **Reset** (sync, `reset`=1 at the clock edge):
  - `count`=0, reload register=0, state IDLE, `busy`=0, `done`=0.
  - Reset overrides every other input.
  - Reset mid-run aborts the run with no `done` pulse.
- **States:** IDLE, RUN, HOLD, DONE, with a 2-bit encoding.
- **Priority per cycle:** reset > load > start > tick/pause.
- **load** (any state):
  - `count` <= `load_val`, reload register <= `load_val`, state <= IDLE, `done`=0.
  - A simultaneous `start` or tick is ignored.
- **IDLE:**
  - `start`=1 with `count`!=0 -> RUN.
  - `start`=1 with `count`==0 -> ignored, stay IDLE.
- **RUN:**
  - `pause`=1 -> HOLD; a tick in the same cycle is ignored.
  - Else if `tick_in`=1:
    - `count`>1 -> `count`-1.
    - `count`==1 with `auto_reload`=1 -> `count` <= reload register, stay RUN, `done` high next cycle.
    - `count`==1 with `auto_reload`=0 -> `count` <= 0, state DONE, `done` high next cycle.
- **HOLD:**
  - Ticks are ignored and `count` is frozen.
  - `pause`=0 -> RUN.
  - `start` has no extra effect.
- **DONE:**
  - `busy`=0 and `count`=0.
  - `start`=1 with reload register !=0 -> `count` <= reload register, RUN.
  - `start`=1 with reload register ==0 -> stay DONE.
- **done:**
  - Registered, exactly one cycle wide, asserted in the cycle after the terminal tick edge.
  - Consecutive terminal ticks (reload=1, `auto_reload`=1, `tick_in` held high) give a `done` pulse every cycle.
- **busy:** registered, derived from the next state; high in RUN and HOLD.
- **Latency:** a tick sampled at edge N is visible on `count` after edge N.
- **tick_in handling:** sampled as a level; a `tick_in` held high for k cycles in RUN gives k decrements, with no edge detection.
- **Arithmetic:** no wrap below 0; a decrement never occurs at `count`==0.

Decomposition:
- Package `temporizador_pkg` holds:
  - the state encoding constants (IDLE=0, RUN=1, HOLD=2, DONE=3);
  - the default WIDTH.
- Single module, no sub-modules: the FSM and the datapath counter live in one file (~150 lines).

Test Plan:
1. Reset, then `load_val`=3, `load`, `start`, three single-cycle `tick_in` pulses 5 cycles apart.
   - Required: `count` 3->2->1->0, `done` high exactly one cycle after the third tick, state DONE, `busy`=0.
2. `auto_reload`=1, `load_val`=2, `start`, `tick_in` held high for 6 cycles.
   - Required: `count` 2,1,2,1,2,1.
   - Required: `done` pulses after tick 2, 4 and 6; `busy` stays 1.
3. `load_val`=5, run, two ticks (`count`=3), `pause`=1 plus 4 ticks, then `pause`=0 plus 1 tick.
   - Required: `count` holds at 3 during HOLD, then goes to 2; `busy`=1 throughout.
4. `count`=4 in RUN, `reset` asserted together with a tick.
   - Required: next cycle `count`=0, IDLE, `busy`=0, no `done`.
5. In RUN with `count`=7, assert `load`(`load_val`=9), `start` and `tick_in` in the same cycle.
   - Required: `count`=9, IDLE, `busy`=0.
   - Then `start` with `load_val`=0 loaded -> stays IDLE.
6. From DONE (reload=3), `start`.
   - Required: `count`=3, RUN; three ticks later `done` pulses again.
